// File: rtl/ex_alu_stage_if.sv
// ex_alu_stage_if: ID/EX operand bundle in, EX/MEM result bundle out
interface ex_alu_stage_if #(
   parameter int NB_DATA      = 32,
   parameter int NB_REG       = 5,
   parameter int NB_ALU_CTRLI = 4
);
   logic                    i_enable;
   logic                    i_flush;
   logic                    i_valid;
   logic [NB_ALU_CTRLI-1:0] i_alu_ctrl;
   logic                    i_shamt_ctrl;
   logic                    i_r31_ctrl;
   logic                    i_alu_src;
   logic                    i_reg_dst;
   logic [NB_DATA-1:0]      i_data_a;
   logic [NB_DATA-1:0]      i_data_b;
   logic [NB_DATA-1:0]      i_imm;
   logic [4:0]              i_shamt;
   logic [NB_DATA-1:0]      i_pc_plus4;
   logic [NB_REG-1:0]       i_rt;
   logic [NB_REG-1:0]       i_rd;
   logic [NB_DATA-1:0]      o_result;
   logic [NB_DATA-1:0]      o_store_data;
   logic [NB_REG-1:0]       o_write_reg;
   logic                    o_branch_taken;
   logic                    o_valid;
   logic [31:0]             o_retired;

   modport slave (
      input  i_enable, i_flush, i_valid, i_alu_ctrl, i_shamt_ctrl, i_r31_ctrl,
             i_alu_src, i_reg_dst, i_data_a, i_data_b, i_imm, i_shamt,
             i_pc_plus4, i_rt, i_rd,
      output o_result, o_store_data, o_write_reg, o_branch_taken, o_valid, o_retired
   );

   modport master (
      output i_enable, i_flush, i_valid, i_alu_ctrl, i_shamt_ctrl, i_r31_ctrl,
             i_alu_src, i_reg_dst, i_data_a, i_data_b, i_imm, i_shamt,
             i_pc_plus4, i_rt, i_rd,
      input  o_result, o_store_data, o_write_reg, o_branch_taken, o_valid, o_retired
   );
endinterface

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: registered MIPS execute stage with EX/MEM capture and retired counter
module ex_alu_stage #(
   parameter int NB_DATA      = 32,
   parameter int NB_REG       = 5,
   parameter int NB_ALU_CTRLI = 4
) (
   input  logic               i_clock,
   input  logic               i_reset,
   ex_alu_stage_if.slave      bus
);
   logic [NB_DATA-1:0] op_b, alu_res, res_new;
   logic [4:0]         sh_amt;
   logic               br_cond;
   logic [NB_REG-1:0]  wreg_new;
   logic [NB_DATA-1:0] result_d, result_q, store_d, store_q;
   logic [NB_REG-1:0]  wreg_d, wreg_q;
   logic               branch_d, branch_q, valid_d, valid_q;
   logic [31:0]        retired_d, retired_q;

   // ALU datapath: operand select, operation decode, branch compare
   always_comb begin
      op_b    = bus.i_alu_src ? bus.i_imm : bus.i_data_b;
      sh_amt  = bus.i_shamt_ctrl ? bus.i_data_a[4:0] : bus.i_shamt;
      alu_res = '0;
      br_cond = 1'b0;
      case (bus.i_alu_ctrl)
         4'h0: alu_res = op_b << sh_amt;
         4'h1: alu_res = op_b >> sh_amt;
         4'h2: alu_res = $signed(op_b) >>> sh_amt;
         4'h3: alu_res = bus.i_data_a + op_b;
         4'h4: alu_res = bus.i_data_a - op_b;
         4'h5: alu_res = bus.i_data_a & op_b;
         4'h6: alu_res = bus.i_data_a | op_b;
         4'h7: alu_res = bus.i_data_a ^ op_b;
         4'h8: alu_res = ~(bus.i_data_a | op_b);
         4'h9: alu_res = {{(NB_DATA-1){1'b0}}, $signed(bus.i_data_a) < $signed(op_b)};
         4'hA: alu_res = {op_b[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
         4'hB: br_cond = bus.i_data_a == op_b;
         4'hC: br_cond = bus.i_data_a != op_b;
         default: alu_res = '0;
      endcase
      res_new  = bus.i_r31_ctrl ? bus.i_pc_plus4 : alu_res;
      wreg_new = bus.i_r31_ctrl ? NB_REG'(31) : (bus.i_reg_dst ? bus.i_rd : bus.i_rt);
   end

   // Next EX/MEM state: enable captures, flush squashes valid/branch and wins over hold
   always_comb begin
      result_d  = result_q;
      store_d   = store_q;
      wreg_d    = wreg_q;
      branch_d  = branch_q;
      valid_d   = valid_q;
      retired_d = retired_q;
      if (bus.i_enable) begin
         result_d  = res_new;
         store_d   = bus.i_data_b;
         wreg_d    = wreg_new;
         branch_d  = br_cond & bus.i_valid;
         valid_d   = bus.i_valid;
         retired_d = retired_q + {31'b0, bus.i_valid};
      end
      if (bus.i_flush) begin
         valid_d   = 1'b0;
         branch_d  = 1'b0;
         retired_d = retired_q;
      end
   end

   // EX/MEM pipeline registers with asynchronous active-low clear
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         result_q  <= '0;
         store_q   <= '0;
         wreg_q    <= '0;
         branch_q  <= 1'b0;
         valid_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         result_q  <= result_d;
         store_q   <= store_d;
         wreg_q    <= wreg_d;
         branch_q  <= branch_d;
         valid_q   <= valid_d;
         retired_q <= retired_d;
      end
   end

   assign bus.o_result       = result_q;
   assign bus.o_store_data   = store_q;
   assign bus.o_write_reg    = wreg_q;
   assign bus.o_branch_taken = branch_q;
   assign bus.o_valid        = valid_q;
   assign bus.o_retired      = retired_q;
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: scoreboard bench with a behavioural execute-stage model
module tb_ex_alu_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ex_alu_stage_if bus ();
   ex_alu_stage dut (.i_clock(clk), .i_reset(rst_n), .bus(bus));

   typedef struct {
      logic en, fl, v, shc, r31, src, dst;
      logic [3:0] ctrl;
      logic [31:0] a, b, imm, pc;
      logic [4:0] sh, rt, rd;
   } stim_t;

   typedef struct {
      logic [31:0] res, sd, ret;
      logic [4:0] wr;
      logic br, v;
   } exp_t;

   exp_t q[$];
   exp_t st;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural meaning of one edge: what the EX/MEM outputs become
   function automatic exp_t next(exp_t p, stim_t s);
      exp_t n = p;
      logic [31:0] bb, r;
      logic [4:0] sh;
      logic br;
      bb = s.src ? s.imm : s.b;
      sh = s.shc ? s.a[4:0] : s.sh;
      r  = 0;
      br = 0;
      case (s.ctrl)
         0: r = bb << sh;
         1: r = bb >> sh;
         2: r = $signed(bb) >>> sh;
         3: r = s.a + bb;
         4: r = s.a - bb;
         5: r = s.a & bb;
         6: r = s.a | bb;
         7: r = s.a ^ bb;
         8: r = ~(s.a | bb);
         9: r = ($signed(s.a) < $signed(bb)) ? 1 : 0;
         10: r = bb << 16;
         11: br = (s.a == bb);
         12: br = (s.a != bb);
         default: r = 0;
      endcase
      if (s.en) begin
         n.res = s.r31 ? s.pc : r;
         n.wr  = s.r31 ? 5'd31 : (s.dst ? s.rd : s.rt);
         n.sd  = s.b;
         n.v   = s.v && !s.fl;
         n.br  = br && n.v;
         if (n.v) n.ret = p.ret + 1;
      end
      if (s.fl) begin
         n.v = 0;
         n.br = 0;
      end
      return n;
   endfunction

   task automatic drv(stim_t s);
      bus.i_enable = s.en;      bus.i_flush = s.fl;        bus.i_valid = s.v;
      bus.i_alu_ctrl = s.ctrl;  bus.i_shamt_ctrl = s.shc;  bus.i_r31_ctrl = s.r31;
      bus.i_alu_src = s.src;    bus.i_reg_dst = s.dst;     bus.i_data_a = s.a;
      bus.i_data_b = s.b;       bus.i_imm = s.imm;         bus.i_shamt = s.sh;
      bus.i_pc_plus4 = s.pc;    bus.i_rt = s.rt;           bus.i_rd = s.rd;
   endtask

   task automatic step(stim_t s);
      @(negedge clk);
      drv(s);
      st = next(st, s);
      q.push_back(st);
   endtask

   function automatic stim_t op(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      stim_t s = '{default: '0};
      s.en = 1; s.v = 1; s.ctrl = c; s.a = a; s.b = b;
      s.rt = 5'd2; s.rd = 5'd3; s.pc = 32'h40;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.en = $urandom_range(0, 3) != 0;
      s.fl = $urandom_range(0, 7) == 0;
      s.v = $urandom_range(0, 3) != 0;
      s.shc = 1'($urandom); s.r31 = $urandom_range(0, 7) == 0;
      s.src = 1'($urandom); s.dst = 1'($urandom);
      s.ctrl = 4'($urandom);
      s.a = $urandom;
      s.b = ($urandom_range(0, 3) == 0) ? s.a : $urandom;
      s.imm = ($urandom_range(0, 3) == 0) ? s.a : $urandom;
      s.pc = $urandom; s.sh = 5'($urandom); s.rt = 5'($urandom); s.rd = 5'($urandom);
      return s;
   endfunction

   task automatic chk_zero(string tag);
      chk({tag, "_result"}, bus.o_result, 0);
      chk({tag, "_store"}, bus.o_store_data, 0);
      chk({tag, "_wreg"}, 32'(bus.o_write_reg), 0);
      chk({tag, "_branch"}, 32'(bus.o_branch_taken), 0);
      chk({tag, "_valid"}, 32'(bus.o_valid), 0);
      chk({tag, "_retired"}, bus.o_retired, 0);
   endtask

   // Monitor: every edge that had stimulus queued is compared just after the edge
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("result", bus.o_result, e.res);
         chk("store_data", bus.o_store_data, e.sd);
         chk("write_reg", 32'(bus.o_write_reg), 32'(e.wr));
         chk("branch_taken", 32'(bus.o_branch_taken), 32'(e.br));
         chk("valid", 32'(bus.o_valid), 32'(e.v));
         chk("retired", bus.o_retired, e.ret);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s, idle;
      idle = '{default: '0};
      st = '{default: '0};
      drv(idle);
      #3 chk_zero("por");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step(op(4'd3, i, 1));
      step(idle);
      @(posedge clk);
      #3 rst_n = 1'b0;
      st = '{default: '0};
      #1 chk_zero("async_rst");
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      step(op(4'd3, 3, 4));
      s = op(4'd2, 0, 32'h8000_0000); s.sh = 4; step(s);
      s = op(4'd0, 32'h23, 1); s.shc = 1; step(s);
      step(op(4'd3, 32'hFFFF_FFFF, 1));
      step(op(4'd9, 32'hFFFF_FFFF, 1));
      s = op(4'd10, 0, 0); s.src = 1; s.imm = 32'h1234; step(s);
      step(op(4'd11, 32'h55, 32'h55));
      step(op(4'd12, 32'h55, 32'h55));
      s = op(4'd11, 32'h55, 32'h55); s.fl = 1; step(s);
      s = op(4'd3, 1, 2); s.r31 = 1; s.pc = 32'h100; step(s);
      s = op(4'd6, 1, 2); s.dst = 1; s.rd = 5'd9; step(s);
      for (int i = 0; i < 3; i++) begin
         s = rnd(); s.en = 0; s.fl = 0; step(s);
      end
      s = rnd(); s.en = 0; s.fl = 1; step(s);
      step(idle);
      @(posedge clk);
      #3 force dut.retired_q = 32'hFFFF_FFFF;
      #1 release dut.retired_q;
      st.ret = 32'hFFFF_FFFF;
      step(idle);
      step(op(4'd3, 1, 1));
      for (int i = 0; i < 400; i++) step(rnd());
      step(idle);
      step(idle);
      @(posedge clk);
      #3 chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
